// File: rtl/mic_level_meter_pkg.sv
// Shared types and helpers for the microphone level meter.
// Used by mic_level_meter (optional DC removal: MIC_LEVEL_METER_DC_REMOVE_EN).
package mic_level_meter_pkg;

    typedef enum logic [1:0] {
        TRACK,
        HOLD,
        DECAY
    } peak_state_t;

    // Magnitude of a signed value of width w, clamped so -2^(w-1) maps to 2^(w-1)-1.
    function automatic logic [63:0] sat_abs(input logic signed [63:0] x, input int w);
        logic signed [63:0] mag;
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        mag = (x < 0) ? -x : x;
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

    // Lowest n bits set.
    function automatic logic [63:0] thermometer(input int n);
        if (n >= 64) begin
            return '1;
        end
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/msb_bitlen.sv
// Combinational priority encoder: index of the highest set bit plus one, 0 for zero input.
module msb_bitlen #(
    parameter int width = 23,
    parameter int w_out = $clog2(width + 1)
) (
    input  logic [width-1:0] x,
    output logic [w_out-1:0] bitlen
);

    always_comb begin
        bitlen = '0;
        for (int i = 0; i < width; i++) begin
            if (x[i]) begin
                bitlen = w_out'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed peak meter with logarithmic LED bar and peak-hold dot.
// Define MIC_LEVEL_METER_DC_REMOVE_EN to subtract a slow DC estimate before measuring.
module mic_level_meter
    import mic_level_meter_pkg::*;
#(
    parameter int w_mic         = 24,
    parameter int w_led         = 18,
    parameter int window_cycles = 1000000,
    parameter int hold_windows  = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [w_mic-1:0]              mic,
    output logic [w_mic-2:0]              level,
    output logic [$clog2(w_led+1)-1:0]    lit,
    output logic [$clog2(w_led+1)-1:0]    peak_pos,
    output logic                          level_valid,
    output logic [w_led-1:0]              led
);

    localparam int w_lvl  = w_mic - 1;
    localparam int lw     = $clog2(w_led + 1);
    localparam int bw     = $clog2(w_mic);
    localparam int offset = w_mic - 1 - w_led;
    localparam int cw     = $clog2(window_cycles);
    localparam int hw     = $clog2(hold_windows + 1);

    localparam logic [cw-1:0] last_count = cw'(window_cycles - 1);
    localparam logic [hw-1:0] hold_init  = hw'(hold_windows);
    localparam logic [hw-1:0] hold_one   = hw'(1);

    logic [cw-1:0]           win_cnt;
    logic                    tick;
    logic signed [w_mic-1:0] s;
    logic [63:0]             abs_wide;
    logic [w_lvl-1:0]        a;
    logic [w_lvl-1:0]        cur_max;
    logic [w_lvl-1:0]        new_level;
    logic [bw-1:0]           new_bitlen;
    logic [lw-1:0]           lit_new;
    peak_state_t             state;
    peak_state_t             state_n;
    logic [lw-1:0]           peak_n;
    logic [hw-1:0]           hold_cnt;
    logic [hw-1:0]           hold_n;
    logic [63:0]             therm_wide;
    logic [w_led-1:0]        led_n;
    logic                    unused_bits;

    assign tick = (win_cnt == last_count);

`ifdef MIC_LEVEL_METER_DC_REMOVE_EN
    localparam logic signed [w_mic+1:0] s_max = (w_mic+2)'((64'sd1 <<< (w_mic - 1)) - 64'sd1);
    localparam logic signed [w_mic+1:0] s_min = ~s_max;

    logic signed [w_mic:0]   dc;
    logic signed [w_mic+1:0] diff;
    logic signed [w_mic+1:0] dc_sum;

    always_comb begin
        diff   = (w_mic+2)'($signed(mic)) - (w_mic+2)'(dc);
        dc_sum = (w_mic+2)'(dc) + (diff >>> 4);
        if (diff > s_max) begin
            s = s_max[w_mic-1:0];
        end else if (diff < s_min) begin
            s = s_min[w_mic-1:0];
        end else begin
            s = diff[w_mic-1:0];
        end
    end

    // The DC estimate only moves once per window so it tracks offset, not audio.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dc <= '0;
        end else if (tick) begin
            dc <= dc_sum[w_mic:0];
        end
    end

    assign unused_bits = ^{abs_wide[63:w_lvl], therm_wide[63:w_led], dc_sum[w_mic+1]};
`else
    assign s           = $signed(mic);
    assign unused_bits = ^{abs_wide[63:w_lvl], therm_wide[63:w_led]};
`endif

    always_comb begin
        abs_wide  = sat_abs(64'(s), w_mic);
        a         = abs_wide[w_lvl-1:0];
        new_level = (a > cur_max) ? a : cur_max;
    end

    msb_bitlen #(
        .width (w_lvl),
        .w_out (bw)
    ) u_bitlen (
        .x      (new_level),
        .bitlen (new_bitlen)
    );

    // Bar length drops the lowest `offset` octaves so the top LED means near full scale.
    always_comb begin
        if (int'(new_bitlen) > offset) begin
            lit_new = lw'(int'(new_bitlen) - offset);
        end else begin
            lit_new = '0;
        end
    end

    always_comb begin
        state_n = state;
        peak_n  = peak_pos;
        hold_n  = hold_cnt;
        if (tick) begin
            if (lit_new >= peak_pos) begin
                if (lit_new != '0) begin
                    peak_n  = lit_new;
                    hold_n  = hold_init;
                    state_n = HOLD;
                end else begin
                    peak_n  = '0;
                    state_n = TRACK;
                end
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt <= hold_one) begin
                            hold_n  = '0;
                            state_n = DECAY;
                        end else begin
                            hold_n = hold_cnt - 1'b1;
                        end
                    end
                    DECAY: begin
                        peak_n = peak_pos - 1'b1;
                        if (peak_pos == lw'(1)) begin
                            state_n = TRACK;
                        end
                    end
                    default: begin
                        peak_n  = '0;
                        state_n = TRACK;
                    end
                endcase
            end
        end
    end

    always_comb begin
        therm_wide = thermometer(int'(lit_new));
        led_n      = therm_wide[w_led-1:0];
        if (peak_n != '0) begin
            led_n = led_n | ({{(w_led-1){1'b0}}, 1'b1} << (peak_n - 1'b1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= TRACK;
            peak_pos <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            peak_pos <= peak_n;
            hold_cnt <= hold_n;
        end
    end

    // The sample present on the tick cycle still belongs to the window that is closing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            cur_max     <= '0;
            level       <= '0;
            lit         <= '0;
            led         <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= tick;
            if (tick) begin
                win_cnt <= '0;
                cur_max <= '0;
                level   <= new_level;
                lit     <= lit_new;
                led     <= led_n;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                cur_max <= new_level;
            end
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed plus randomized bench for mic_level_meter against a per-window arithmetic model.
module tb_mic_level_meter;

    localparam int WMIC   = 24;
    localparam int WLED   = 18;
    localparam int WINDOW = 16;
    localparam int HOLDW  = 2;
    localparam int OFFSET = WMIC - 1 - WLED;
    localparam longint AMAX = (64'sd1 <<< (WMIC - 1)) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WMIC-1:0]   mic;
    logic [WMIC-2:0]   level;
    logic [4:0]        lit;
    logic [4:0]        peak_pos;
    logic              level_valid;
    logic [WLED-1:0]   led;

    int vectors     = 0;
    int miscompares = 0;

    int     cyc;
    longint winMax;
    int     peakM;
    int     holdLeft;
    longint dcM;
    longint expLevel;
    longint expLit;
    longint expPeak;
    longint expLed;
    bit     expValid;

    mic_level_meter #(
        .w_mic         (WMIC),
        .w_led         (WLED),
        .window_cycles (WINDOW),
        .hold_windows  (HOLDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mic         (mic),
        .level       (level),
        .lit         (lit),
        .peak_pos    (peak_pos),
        .level_valid (level_valid),
        .led         (led)
    );

    always #5 clk = ~clk;

    function automatic int bitlenOf(input longint v);
        int n = 0;
        while (v > 0) begin
            v = v >> 1;
            n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock of stimulus; the model is updated with what the edge should do.
    task automatic applyStimulus(input logic r, input logic [WMIC-1:0] m);
        longint s;
        longint a;
        rst_n = r;
        mic   = m;
        @(posedge clk);
        if (!r) begin
            cyc = 0; winMax = 0; peakM = 0; holdLeft = 0; dcM = 0;
            expLevel = 0; expLit = 0; expPeak = 0; expLed = 0; expValid = 0;
        end else begin
            s = longint'($signed(m));
`ifdef MIC_LEVEL_METER_DC_REMOVE_EN
            s = s - dcM;
            if (s > AMAX) s = AMAX;
            if (s < -AMAX - 1) s = -AMAX - 1;
`endif
            a = (s < 0) ? -s : s;
            if (a > AMAX) a = AMAX;
            if (a > winMax) winMax = a;
            expValid = 0;
            if (cyc == WINDOW - 1) begin
                expLevel = winMax;
                expLit   = (bitlenOf(winMax) > OFFSET) ? bitlenOf(winMax) - OFFSET : 0;
                if (expLit >= peakM && expLit > 0) begin
                    peakM    = int'(expLit);
                    holdLeft = HOLDW;
                end else if (expLit < peakM) begin
                    if (holdLeft > 0) holdLeft--;
                    else peakM--;
                end
                expPeak  = peakM;
                expLed   = ((64'sd1 <<< expLit) - 1) | ((peakM > 0) ? (64'sd1 <<< (peakM - 1)) : 0);
                expValid = 1;
                winMax   = 0;
                cyc      = 0;
                dcM      = dcM + ((longint'($signed(m)) - dcM) >>> 4);
            end else begin
                cyc++;
            end
        end
        @(negedge clk);
        checkOutput("level_valid", 64'(level_valid), 64'(expValid));
        checkOutput("level", 64'(level), expLevel);
        checkOutput("lit", 64'(lit), expLit);
        checkOutput("peak_pos", 64'(peak_pos), expPeak);
        checkOutput("led", 64'(led), expLed);
    endtask

    initial begin
        logic [WMIC-1:0] r;
        rst_n = 1'b0;
        mic   = '0;
        @(negedge clk);

        $display("[TB] reset with full-scale input");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h7FFFFF);

        $display("[TB] constant 2^22");
        for (int i = 0; i < 2 * WINDOW; i++) applyStimulus(1'b1, 24'h400000);

        $display("[TB] single most-negative sample");
        for (int i = 0; i < WINDOW; i++) applyStimulus(1'b1, (i == 7) ? 24'h800000 : 24'h000000);
        for (int i = 0; i < WINDOW; i++) applyStimulus(1'b1, 24'h000000);

        $display("[TB] peak hold and decay");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 24'h000000);
        for (int i = 0; i < WINDOW; i++) applyStimulus(1'b1, 24'h400000);
        for (int i = 0; i < 21 * WINDOW; i++) applyStimulus(1'b1, 24'h000000);
        checkOutput("peak_idle", 64'(peak_pos), 64'd0);
        checkOutput("led_idle", 64'(led), 64'd0);

        $display("[TB] tick-cycle capture");
        for (int i = 0; i < WINDOW; i++) applyStimulus(1'b1, (i == WINDOW - 1) ? 24'h000100 : 24'h000000);
        checkOutput("tick_level", 64'(level), 64'd256);
        checkOutput("tick_lit", 64'(lit), 64'd4);
        for (int i = 0; i < WINDOW; i++) applyStimulus(1'b1, 24'h000000);

        $display("[TB] random windows");
        for (int w = 0; w < 10; w++) begin
            for (int i = 0; i < WINDOW; i++) begin
                r = WMIC'($urandom) >> $urandom_range(2 + w, 23);
                if ($urandom_range(0, 3) == 0) r = -r;
                if ($urandom_range(0, 60) == 0) r = 24'h800000;
                applyStimulus(1'b1, r);
            end
        end

        $display("[TB] reset mid-window");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 24'h7FFFFF);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 24'h7FFFFF);
        for (int i = 0; i < 2 * WINDOW; i++) applyStimulus(1'b1, 24'h000000);

        $display("[TB] constant 2^20");
        for (int i = 0; i < 4 * WINDOW; i++) applyStimulus(1'b1, 24'h100000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
